// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared cell, result and controller-state types plus board helpers
package tictactoe_pkg;
  localparam int NUM_CELLS = 9;
  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
  typedef enum logic [1:0] {NONE = 2'b00, P1_WIN = 2'b01, P2_WIN = 2'b10, DRAW = 2'b11} result_t;
  typedef enum logic [1:0] {IDLE = 2'b00, TURN = 2'b01, CHECK = 2'b10, OVER = 2'b11} ctrl_state_t;
  // cell0 sits in the top bits of the packed board; out-of-range indices read as empty
  function automatic logic [1:0] cell_at(input logic [2*NUM_CELLS-1:0] b, input logic [3:0] idx);
    logic [1:0] c;
    c = 2'b00;
    for (int i = 0; i < NUM_CELLS; i++)
      if (idx == 4'(i)) c = b[2*(NUM_CELLS-1-i) +: 2];
    return c;
  endfunction
endpackage

// File: rtl/turn_controller_if.sv
// turn_controller_if: move requests, board/win inputs and cell-write/status outputs
// master: player/board side (drives requests, board, win); slave: the controller
interface turn_controller_if;
  import tictactoe_pkg::*;
  logic                   new_game;
  logic                   move_req;
  logic [3:0]             move_idx;
  logic [2*NUM_CELLS-1:0] board;
  logic [1:0]             win;
  logic                   wr_en;
  logic [3:0]             wr_idx;
  logic [1:0]             wr_val;
  logic                   clr_board;
  logic                   move_ack;
  logic                   move_err;
  logic [1:0]             cur_player;
  logic                   game_over;
  logic [1:0]             result;
  logic [3:0]             move_cnt;
  modport master (output new_game, move_req, move_idx, board, win,
                  input wr_en, wr_idx, wr_val, clr_board, move_ack, move_err,
                  cur_player, game_over, result, move_cnt);
  modport slave (input new_game, move_req, move_idx, board, win,
                 output wr_en, wr_idx, wr_val, clr_board, move_ack, move_err,
                 cur_player, game_over, result, move_cnt);
endinterface

// File: rtl/turn_controller_edge_detect.sv
// edge_detect: one-cycle pulse on a 0->1 transition of i_sig
// Ports: clk, reset (async active-low), i_sig level in, o_rise pulse out.
// A level already high when reset releases is not reported as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev, r_arm;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_arm  <= 1'b1;
    end
  end
  assign o_rise = r_arm & i_sig & ~r_prev;
endmodule

// File: rtl/turn_controller.sv
// turn_controller: tic-tac-toe turn sequencer and sole writer of the board
// Ports: clk, reset (async active-low), bus (turn_controller_if.slave): move
// requests, board and win in; cell writes, board clear, ack/err and game status out.
// Macro TURN_TIMEOUT_EN: a turn idle for TIMEOUT_CYCLES passes to the other player.
module turn_controller
  import tictactoe_pkg::*;
#(
  parameter int CHECK_LAT      = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input logic clk,
  input logic reset,
  turn_controller_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_TURN  = TURN;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_OVER  = OVER;
  logic [1:0] r_state, r_cur, r_first, r_wr_val, r_res;
  logic [3:0] r_wr_idx, r_cnt;
  logic [7:0] r_chk;
  logic       r_wr_en, r_clr, r_ack, r_err;
  logic       w_ng, w_valid, w_acc, w_tmo;
  logic [1:0] w_other, w_nfirst;
  edge_detect u_ng (.clk(clk), .reset(reset), .i_sig(bus.new_game), .o_rise(w_ng));
  assign w_valid  = bus.move_idx < 4'(NUM_CELLS) && cell_at(bus.board, bus.move_idx) == EMPTY;
  assign w_acc    = r_state == S_TURN && bus.move_req && w_valid;
  // players are 01/10, so swapping the bits toggles between them
  assign w_other  = {r_cur[0], r_cur[1]};
  assign w_nfirst = {r_first[0], r_first[1]};
`ifdef TURN_TIMEOUT_EN
  logic [31:0] r_to;
  assign w_tmo = r_state == S_TURN && r_to == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_to <= '0;
    else r_to <= (r_state == S_TURN && !w_ng && !w_acc && !w_tmo) ? r_to + 32'd1 : '0;
  end
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur    <= P1;
      r_first  <= P1;
      r_wr_val <= 2'b00;
      r_wr_idx <= 4'd0;
      r_res    <= NONE;
      r_cnt    <= 4'd0;
      r_chk    <= 8'd0;
      r_wr_en  <= 1'b0;
      r_clr    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_clr   <= w_ng;
      r_wr_en <= w_acc && !w_ng;
      r_ack   <= w_acc && !w_ng;
      r_err   <= r_state == S_TURN && !w_ng && !w_acc && (w_tmo || bus.move_req);
      if (w_ng) begin
        // the very first game keeps P1; every later start alternates the opener
        r_state <= S_TURN;
        r_cnt   <= 4'd0;
        r_res   <= NONE;
        r_first <= (r_state == S_IDLE) ? r_first : w_nfirst;
        r_cur   <= (r_state == S_IDLE) ? r_first : w_nfirst;
      end else if (w_acc) begin
        r_state  <= S_CHECK;
        r_chk    <= 8'd0;
        r_wr_idx <= bus.move_idx;
        r_wr_val <= r_cur;
        r_cnt    <= (r_cnt == 4'd9) ? r_cnt : r_cnt + 4'd1;
      end else if (w_tmo) begin
        r_cur <= w_other;
      end else if (r_state == S_CHECK) begin
        if (r_chk != 8'(CHECK_LAT)) r_chk <= r_chk + 8'd1;
        else if (bus.win != NONE) begin
          r_res   <= bus.win;
          r_state <= S_OVER;
        end else if (r_cnt == 4'd9) begin
          r_res   <= DRAW;
          r_state <= S_OVER;
        end else begin
          r_cur   <= w_other;
          r_state <= S_TURN;
        end
      end
    end
  end
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_idx     = r_wr_idx;
  assign bus.wr_val     = r_wr_val;
  assign bus.clr_board  = r_clr;
  assign bus.move_ack   = r_ack;
  assign bus.move_err   = r_err;
  assign bus.cur_player = (r_state == S_TURN) ? r_cur : 2'b00;
  assign bus.game_over  = r_state == S_OVER;
  assign bus.result     = r_res;
  assign bus.move_cnt   = r_cnt;
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed and randomized checks of turn_controller against a game-level model
module tb_turn_controller;
  localparam int CL = 2;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  turn_controller_if bus ();
  turn_controller #(.CHECK_LAT(CL), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  task automatic ck(input string nm, input logic [3:0] a, input logic [3:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // cell register array and a victory register that only reports real lines (never draws)
  logic [1:0] cells [9];
  logic [1:0] winr, win_force;
  int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  function automatic logic [1:0] line_win();
    for (int l = 0; l < 8; l++)
      if (cells[ln[l][0]] != 2'b00 && cells[ln[l][0]] == cells[ln[l][1]] && cells[ln[l][1]] == cells[ln[l][2]])
        return cells[ln[l][0]];
    return 2'b00;
  endfunction
  for (genvar g = 0; g < 9; g++) assign bus.board[17-2*g -: 2] = cells[g];
  assign bus.win = (win_force != 2'b00) ? win_force : winr;
  always @(posedge clk or negedge reset) begin
    if (!reset || bus.clr_board) begin
      for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
      winr <= 2'b00;
    end else begin
      if (bus.wr_en && bus.wr_idx < 4'd9) cells[bus.wr_idx] <= bus.wr_val;
      winr <= line_win();
    end
  end
  // game model: ph 0 waiting for first game, 1 player to move, 2 awaiting verdict, 3 finished
  int ph, wait_left, idle, cnt;
  logic [1:0] cur, first, res, e_val;
  logic [3:0] e_idx;
  bit prev, armed, e_clr, e_wr, e_ack, e_err;
  function automatic logic [1:0] other(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; wait_left = 0; idle = 0; cnt = 0;
      cur = 2'b01; first = 2'b01; res = 2'b00;
      prev = 0; armed = 0;
      e_clr = 0; e_wr = 0; e_ack = 0; e_err = 0; e_idx = 0; e_val = 0;
    end else begin
      bit rise, ok;
      rise = armed && bus.new_game && !prev;
      armed = 1;
      prev = bus.new_game;
      ok = ph == 1 && bus.move_req && bus.move_idx < 4'd9 && cells[bus.move_idx] == 2'b00;
      e_clr = rise; e_wr = 0; e_ack = 0; e_err = 0;
      if (rise) begin
        cnt = 0; res = 2'b00; idle = 0;
        if (ph != 0) first = other(first);
        cur = first;
        ph = 1;
      end else if (ok) begin
        e_wr = 1; e_ack = 1; e_idx = bus.move_idx; e_val = cur;
        cnt = (cnt < 9) ? cnt + 1 : 9;
        wait_left = CL;
        idle = 0;
        ph = 2;
      end else if (ph == 1) begin
`ifdef TURN_TIMEOUT_EN
        if (idle == TO - 1) begin
          cur = other(cur); e_err = 1; idle = 0;
        end else begin
          e_err = bus.move_req; idle++;
        end
`else
        e_err = bus.move_req;
`endif
      end else if (ph == 2) begin
        if (wait_left > 0) wait_left--;
        else if (bus.win != 2'b00) begin res = bus.win; ph = 3; end
        else if (cnt == 9) begin res = 2'b11; ph = 3; end
        else begin cur = other(cur); ph = 1; end
      end
    end
  end
  always @(negedge clk) begin
    ck("clr_board", bus.clr_board, e_clr);
    ck("wr_en", bus.wr_en, e_wr);
    ck("move_ack", bus.move_ack, e_ack);
    ck("move_err", bus.move_err, e_err);
    ck("cur_player", bus.cur_player, (ph == 1) ? cur : 2'b00);
    ck("game_over", bus.game_over, ph == 3);
    ck("result", bus.result, res);
    ck("move_cnt", bus.move_cnt, 4'(cnt));
    if (e_wr) begin
      ck("wr_idx", bus.wr_idx, e_idx);
      ck("wr_val", bus.wr_val, e_val);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ng_pulse();
    @(negedge clk) bus.new_game = 1'b1;
    @(negedge clk) bus.new_game = 1'b0;
  endtask
  task automatic mv(input logic [3:0] idx);
    @(negedge clk);
    bus.move_req = 1'b1;
    bus.move_idx = idx;
    @(negedge clk) bus.move_req = 1'b0;
  endtask
  int g1 [5] = '{0, 3, 1, 4, 2};
  int g2 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  initial begin
    reset = 1'b1;
    bus.new_game = 1'b0;
    bus.move_req = 1'b0;
    bus.move_idx = 4'd0;
    win_force = 2'b00;
    #1 reset = 1'b0;
    cyc(3);
    ck("rst cur_player", bus.cur_player, 0);
    ck("rst move_cnt", bus.move_cnt, 0);
    ck("rst game_over", bus.game_over, 0);
    @(negedge clk) #2 reset = 1'b1;
    cyc(2);
    ng_pulse();
    ck("start clr_board", bus.clr_board, 1);
    ck("start cur_player", bus.cur_player, 2'b01);
    ck("start move_cnt", bus.move_cnt, 0);
    mv(4);
    ck("p1 wr_en", bus.wr_en, 1);
    ck("p1 wr_idx", bus.wr_idx, 4);
    ck("p1 wr_val", bus.wr_val, 2'b01);
    ck("p1 move_ack", bus.move_ack, 1);
    cyc(3);
    ck("pass cur_player", bus.cur_player, 2'b10);
    mv(4);
    ck("occupied move_err", bus.move_err, 1);
    ck("occupied wr_en", bus.wr_en, 0);
    mv(9);
    ck("idx9 move_err", bus.move_err, 1);
    mv(15);
    ck("idx15 move_err", bus.move_err, 1);
    ck("idx15 cur_player", bus.cur_player, 2'b10);
    ng_pulse();
    ck("abort cur_player", bus.cur_player, 2'b10);
    ck("abort move_cnt", bus.move_cnt, 0);
    foreach (g1[i]) begin mv(4'(g1[i])); cyc(3); end
    ck("win game_over", bus.game_over, 1);
    ck("win result", bus.result, 2'b10);
    ck("win move_cnt", bus.move_cnt, 5);
    mv(5);
    ck("over ack", bus.move_ack, 0);
    ck("over err", bus.move_err, 0);
    ck("over wr_en", bus.wr_en, 0);
    ng_pulse();
    ck("g2 cur_player", bus.cur_player, 2'b01);
    ck("g2 result", bus.result, 0);
    foreach (g2[i]) begin mv(4'(g2[i])); cyc(3); end
    ck("draw result", bus.result, 2'b11);
    ck("draw move_cnt", bus.move_cnt, 9);
    ck("draw game_over", bus.game_over, 1);
    ng_pulse();
    ck("alt cur_player", bus.cur_player, 2'b10);
    mv(0);
    #2 reset = 1'b0;
    #1;
    ck("async wr_en", bus.wr_en, 0);
    ck("async move_ack", bus.move_ack, 0);
    ck("async move_cnt", bus.move_cnt, 0);
    ck("async cur_player", bus.cur_player, 0);
    ck("async result", bus.result, 0);
    @(negedge clk) #2 reset = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      bus.move_req = ($urandom % 3) == 0;
      bus.move_idx = ($urandom % 8 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      if ($urandom % 50 == 0) bus.new_game = ~bus.new_game;
      win_force = ($urandom % 150 == 0) ? 2'b11 : 2'b00;
      if ($urandom % 1500 == 0) begin
        #2 reset = 1'b0;
        @(negedge clk) #2 reset = 1'b1;
      end
    end
    bus.move_req = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
